card_flip_game_ctrl: RTL and testbench
======================================

Name: card_flip_game_ctrl

Overview:
- Top-level game sequencer for the 16-card memory-match game.
- Requests a shuffled deck from the random assignment block (random_start_ver), then latches the 48-bit deck of 16 x 3-bit values (8 pairs).
- Arbitrates player flips and compares pairs; holds mismatches visible for a fixed time, then hides them.
- Tracks matched cards and the move count, and signals game over.

Parameters:
- HOLD_CYCLES, 50_000_000: cycles a mismatched pair stays face-up before hiding; must be >= 1.
- MAX_MOVES, 40: move limit; used only with MOVE_LIMIT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start_game  in  1  one-cycle pulse; begins a new game (shuffle).
- flip  in  1  one-cycle pulse; flip the card at card_sel.
- card_sel  in  4  card index 0..15 qualified by flip.
- rand_start  out  1  start request to the randomizer.
- rand_busy  in  1  randomizer busy.
- random_num  in  48  deck; card k value = bits [3k..3k+2] (bit 3k MSB, ascending [0:47] numbering).
- deck  out  48  latched deck, same layout.
- face_up  out  16  bit k = card k currently shown (unmatched).
- matched  out  16  bit k = card k permanently matched.
- moves  out  8  completed pair attempts, saturating at 255.
- busy  out  1  high in SHUF_REQ, SHUF_WAIT, COMPARE, SHOW_MISS.
- game_over  out  1  high in DONE_WIN or DONE_LOSE.
- game_lost  out  1  high in DONE_LOSE; constant 0 without the macro.

Behaviour:
- Reset: state IDLE. rand_start=0, deck=0, face_up=0, matched=0, moves=0, busy=0, game_over=0, game_lost=0. Reset applies mid-shuffle or mid-hold with no residue; the hold timer and first-card register are cleared.
- All outputs are registered.

States:
- IDLE: start_game -> SHUF_REQ; clears face_up, matched, moves.
- SHUF_REQ: rand_start=1. Stays until rand_busy=1 is sampled, then rand_start drops next cycle -> SHUF_WAIT.
- SHUF_WAIT: waits for rand_busy=0. On the first cycle rand_busy is sampled 0, latches deck<=random_num -> PICK1.
- PICK1: on flip with card_sel not face_up and not matched, sets face_up[sel], records first=sel -> PICK2. Invalid flips are ignored with no state change.
- PICK2: valid flip (not face_up, not matched, sel != first) sets face_up[sel], records second=sel, moves+1 (saturating) -> COMPARE.
- COMPARE (exactly 1 cycle):
  - Values equal: matched[first] and matched[second] <= 1, both face_up bits <= 0. Next state is DONE_WIN if matched becomes all ones, else PICK1.
  - Values differ: load timer=HOLD_CYCLES-1 -> SHOW_MISS.
- SHOW_MISS: timer decrements each cycle; flips are ignored. At timer=0, clears both face_up bits -> PICK1.
- DONE_WIN / DONE_LOSE: hold all outputs; start_game -> SHUF_REQ (new game, counters cleared).

Interaction rules:
- start_game in any state other than IDLE/DONE_* is ignored.
- flip and start_game in the same cycle in a DONE state: start_game wins, flip is dropped.
- A flip in the same cycle the deck is latched (SHUF_WAIT) is dropped.
- Latency:
  - flip to face_up: 1 cycle.
  - Second flip to matched: 2 cycles.
  - Mismatch hide: HOLD_CYCLES+2 cycles after the second flip.

Optional Feature:
- CARD_FLIP_MOVE_LIMIT_EN defined:
  - In COMPARE, a mismatch when moves==MAX_MOVES -> DONE_LOSE, with game_lost=1 and face_up cleared.
  - A match on the final pair still goes to DONE_WIN even at the limit.
- CARD_FLIP_MOVE_LIMIT_EN undefined: no limit, DONE_LOSE is unreachable, and game_lost is tied 0.

Test Plan:
- Reset then start_game with the randomizer model (busy high 10 cycles, deck 0,0,1,1,...,7,7) -> rand_start high until busy seen, deck latched == model value one cycle after busy falls, state PICK1.
- Flip card 0 then card 1 (values 0,0) -> face_up[0] set, then matched=16'h0003, face_up=0, moves=1.
- HOLD_CYCLES=4: flip card 0 then card 2 (values 0,1) -> face_up=16'h0005 for 4 cycles after COMPARE, then 0. Flips during the hold are ignored and moves stays 1.
- Flip a matched card, flip the same card twice, flip during SHUF_WAIT -> no change to face_up, moves or state.
- Match all 8 pairs in order -> matched=16'hFFFF, game_over=1, moves=8. A following start_game clears all and re-requests the shuffle.
- Macro defined with MAX_MOVES=3: three mismatches -> DONE_LOSE, game_lost=1. Separately, assert reset mid-SHOW_MISS -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/card_flip_game_ctrl.sv
// Game sequencer for the 16-card memory-match game: shuffle handshake, flip arbitration,
// pair compare and mismatch hold. Optional move limit enabled by CARD_FLIP_MOVE_LIMIT_EN.
module card_flip_game_ctrl #(
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int MAX_MOVES   = 40
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_game,
    input  logic        flip,
    input  logic [3:0]  card_sel,
    output logic        rand_start,
    input  logic        rand_busy,
    input  logic [0:47] random_num,
    output logic [0:47] deck,
    output logic [15:0] face_up,
    output logic [15:0] matched,
    output logic [7:0]  moves,
    output logic        busy,
    output logic        game_over,
    output logic        game_lost
);

    localparam int TW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_SHUF_REQ  = 4'd1;
    localparam logic [3:0] S_SHUF_WAIT = 4'd2;
    localparam logic [3:0] S_PICK1     = 4'd3;
    localparam logic [3:0] S_PICK2     = 4'd4;
    localparam logic [3:0] S_COMPARE   = 4'd5;
    localparam logic [3:0] S_SHOW_MISS = 4'd6;
    localparam logic [3:0] S_DONE_WIN  = 4'd7;
    localparam logic [3:0] S_DONE_LOSE = 4'd8;

    logic [3:0]    state, next_state;
    logic [3:0]    first, second;
    logic [TW-1:0] timer;
    logic [2:0]    first_val, second_val;
    logic [15:0]   sel_bit, pair_bits;
    logic          flip_ok1, flip_ok2, pair_equal, lose_now, all_matched;

    always_comb begin
        first_val   = deck[6'(first) * 6'd3 +: 3];
        second_val  = deck[6'(second) * 6'd3 +: 3];
        pair_equal  = (first_val == second_val);
        sel_bit     = 16'b1 << card_sel;
        pair_bits   = (16'b1 << first) | (16'b1 << second);
        all_matched = ((matched | pair_bits) == '1);
        flip_ok1    = flip && !face_up[card_sel] && !matched[card_sel];
        flip_ok2    = flip_ok1 && (card_sel != first);
`ifdef CARD_FLIP_MOVE_LIMIT_EN
        lose_now    = (moves == 8'(MAX_MOVES));
`else
        lose_now    = 1'b0;
`endif
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE, S_DONE_WIN, S_DONE_LOSE:
                if (start_game) next_state = S_SHUF_REQ;
            S_SHUF_REQ:
                if (rand_busy) next_state = S_SHUF_WAIT;
            S_SHUF_WAIT:
                if (!rand_busy) next_state = S_PICK1;
            S_PICK1:
                if (flip_ok1) next_state = S_PICK2;
            S_PICK2:
                if (flip_ok2) next_state = S_COMPARE;
            S_COMPARE:
                if (pair_equal)    next_state = all_matched ? S_DONE_WIN : S_PICK1;
                else if (lose_now) next_state = S_DONE_LOSE;
                else               next_state = S_SHOW_MISS;
            S_SHOW_MISS:
                if (timer == '0) next_state = S_PICK1;
            default:
                next_state = S_IDLE;
        endcase
    end

    // Status outputs are registered from next_state so they line up with the state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            rand_start <= 1'b0;
            busy       <= 1'b0;
            game_over  <= 1'b0;
            deck       <= '0;
            face_up    <= '0;
            matched    <= '0;
            moves      <= '0;
            first      <= '0;
            second     <= '0;
            timer      <= '0;
        end else begin
            state      <= next_state;
            rand_start <= (next_state == S_SHUF_REQ);
            busy       <= (next_state == S_SHUF_REQ) || (next_state == S_SHUF_WAIT) ||
                          (next_state == S_COMPARE)  || (next_state == S_SHOW_MISS);
            game_over  <= (next_state == S_DONE_WIN) || (next_state == S_DONE_LOSE);
            case (state)
                S_IDLE, S_DONE_WIN, S_DONE_LOSE: begin
                    if (start_game) begin
                        face_up <= '0;
                        matched <= '0;
                        moves   <= '0;
                    end
                end
                S_SHUF_WAIT: begin
                    if (!rand_busy) deck <= random_num;
                end
                S_PICK1: begin
                    if (flip_ok1) begin
                        face_up <= face_up | sel_bit;
                        first   <= card_sel;
                    end
                end
                S_PICK2: begin
                    if (flip_ok2) begin
                        face_up <= face_up | sel_bit;
                        second  <= card_sel;
                        if (moves != 8'hFF) moves <= moves + 8'd1;
                    end
                end
                S_COMPARE: begin
                    if (pair_equal) begin
                        matched <= matched | pair_bits;
                        face_up <= face_up & ~pair_bits;
                    end else if (lose_now) begin
                        face_up <= '0;
                    end else begin
                        timer <= TW'(HOLD_CYCLES - 1);
                    end
                end
                S_SHOW_MISS: begin
                    if (timer == '0) face_up <= face_up & ~pair_bits;
                    else             timer   <= timer - 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef CARD_FLIP_MOVE_LIMIT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) game_lost <= 1'b0;
        else       game_lost <= (next_state == S_DONE_LOSE);
    end
`else
    assign game_lost = 1'b0;
`endif

endmodule

// File: tb/tb_card_flip_game_ctrl.sv
// Directed scoreboard bench for card_flip_game_ctrl with a behavioural randomizer
// (busy for 10 cycles, deck 0,0,1,1,...,7,7). Covers the move limit when CARD_FLIP_MOVE_LIMIT_EN is set.
module tb_card_flip_game_ctrl;

    localparam int HOLD = 4;

    logic        clk;
    logic        reset;
    logic        start_game;
    logic        flip;
    logic [3:0]  card_sel;
    logic        rand_start;
    logic        rand_busy;
    logic [0:47] random_num;
    logic [0:47] deck;
    logic [15:0] face_up;
    logic [15:0] matched;
    logic [7:0]  moves;
    logic        busy;
    logic        game_over;
    logic        game_lost;

    card_flip_game_ctrl #(
        .HOLD_CYCLES(HOLD),
        .MAX_MOVES  (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start_game(start_game),
        .flip      (flip),
        .card_sel  (card_sel),
        .rand_start(rand_start),
        .rand_busy (rand_busy),
        .random_num(random_num),
        .deck      (deck),
        .face_up   (face_up),
        .matched   (matched),
        .moves     (moves),
        .busy      (busy),
        .game_over (game_over),
        .game_lost (game_lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Randomizer model: a start request seen while idle makes it busy for 10 cycles.
    int unsigned rcnt;
    always @(posedge clk or posedge reset) begin
        if (reset)             rcnt <= 0;
        else if (rcnt != 0)    rcnt <= rcnt - 1;
        else if (rand_start)   rcnt <= 10;
    end
    assign rand_busy = (rcnt != 0);

    function automatic logic [0:47] make_deck();
        logic [0:47] d;
        for (int k = 0; k < 16; k++) d[3*k +: 3] = 3'(k / 2);
        return d;
    endfunction

    typedef struct {
        string       tag;
        logic [63:0] val;
    } exp_t;

    exp_t        sb[$];
    int          n_assert = 0;
    int          n_fail   = 0;
    logic [0:47] model_deck;

    task automatic sb_push(input string tag, input logic [63:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic sb_check(input logic [63:0] obs);
        exp_t e;
        n_assert++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed %0h required an expected entry", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_flip(input logic [3:0] s);
        flip     = 1'b1;
        card_sel = s;
        tick();
        flip     = 1'b0;
    endtask

    task automatic check_reset_vals(input string where);
        sb_push({where, "_rand_start"}, 0);
        sb_push({where, "_deck"}, 0);
        sb_push({where, "_face_up"}, 0);
        sb_push({where, "_matched"}, 0);
        sb_push({where, "_moves"}, 0);
        sb_push({where, "_busy"}, 0);
        sb_push({where, "_game_over"}, 0);
        sb_push({where, "_game_lost"}, 0);
        sb_check(rand_start);
        sb_check(deck);
        sb_check(face_up);
        sb_check(matched);
        sb_check(moves);
        sb_check(busy);
        sb_check(game_over);
        sb_check(game_lost);
    endtask

    // Start pulse, then wait out the randomizer; optionally hammer flips throughout.
    task automatic run_shuffle(input logic [0:47] prev_deck, input bit flip_during);
        bit seen;
        int n;
        sb_push("start_rand_start", 1);
        sb_push("start_busy", 1);
        sb_push("start_matched", 0);
        sb_push("start_moves", 0);
        sb_push("start_game_over", 0);
        start_game = 1'b1;
        if (flip_during) begin
            flip     = 1'b1;
            card_sel = 4'd0;
        end
        tick();
        start_game = 1'b0;
        sb_check(rand_start);
        sb_check(busy);
        sb_check(matched);
        sb_check(moves);
        sb_check(game_over);
        if (flip_during) card_sel = 4'd5;
        seen = 1'b0;
        n    = 0;
        while (!(seen && !rand_busy) && n < 40) begin
            if (rand_busy) seen = 1'b1;
            tick();
            n++;
        end
        sb_push("shuffle_wait_bounded", 1);
        sb_push("shuf_rand_start_dropped", 0);
        sb_push("shuf_busy_wait", 1);
        sb_push("shuf_deck_not_yet", prev_deck);
        sb_check(64'(n < 40));
        sb_check(rand_start);
        sb_check(busy);
        sb_check(deck);
        sb_push("shuf_deck_latched", model_deck);
        sb_push("shuf_busy_pick1", 0);
        sb_push("shuf_face_up", 0);
        tick();
        flip = 1'b0;
        sb_check(deck);
        sb_check(busy);
        sb_check(face_up);
    endtask

    task automatic mismatch_hold(input logic [3:0] a, input logic [3:0] b, input logic [7:0] exp_moves);
        logic [15:0] pair;
        pair = (16'b1 << a) | (16'b1 << b);
        do_flip(a);
        sb_push("miss_face_up_cmp", pair);
        sb_push("miss_moves", exp_moves);
        do_flip(b);
        sb_check(face_up);
        sb_check(moves);
        for (int k = 1; k <= HOLD; k++) begin
            if (k <= 2) begin
                flip     = 1'b1;
                card_sel = 4'd6;
            end
            sb_push("miss_face_up_hold", pair);
            tick();
            flip = 1'b0;
            sb_check(face_up);
        end
        sb_push("miss_face_up_hidden", 0);
        sb_push("miss_busy_after", 0);
        sb_push("miss_moves_after", exp_moves);
        tick();
        sb_check(face_up);
        sb_check(busy);
        sb_check(moves);
    endtask

    initial begin
        model_deck = make_deck();
        random_num = model_deck;
        reset      = 1'b1;
        start_game = 1'b0;
        flip       = 1'b0;
        card_sel   = 4'd0;
        tick(2);
        reset = 1'b0;
        tick();
        check_reset_vals("reset");

        run_shuffle(48'd0, 1'b0);

        // First pair matches: cards 0 and 1 both hold value 0.
        sb_push("m01_face_up0", 16'h0001);
        sb_push("m01_moves0", 0);
        do_flip(4'd0);
        sb_check(face_up);
        sb_check(moves);
        sb_push("m01_face_up_cmp", 16'h0003);
        sb_push("m01_moves_cmp", 1);
        sb_push("m01_busy_cmp", 1);
        sb_push("m01_matched_cmp", 0);
        do_flip(4'd1);
        sb_check(face_up);
        sb_check(moves);
        sb_check(busy);
        sb_check(matched);
        sb_push("m01_matched", 16'h0003);
        sb_push("m01_face_up", 0);
        sb_push("m01_busy", 0);
        tick();
        sb_check(matched);
        sb_check(face_up);
        sb_check(busy);

        mismatch_hold(4'd2, 4'd4, 8'd2);

        // Invalid flips: matched card, repeated card, matched card while picking the second.
        sb_push("inv_matched_face_up", 0);
        sb_push("inv_matched_busy", 0);
        do_flip(4'd0);
        sb_check(face_up);
        sb_check(busy);
        sb_push("inv_first_face_up", 16'h0004);
        do_flip(4'd2);
        sb_check(face_up);
        sb_push("inv_same_face_up", 16'h0004);
        sb_push("inv_same_moves", 2);
        sb_push("inv_same_busy", 0);
        do_flip(4'd2);
        sb_check(face_up);
        sb_check(moves);
        sb_check(busy);
        sb_push("inv_matched2_face_up", 16'h0004);
        sb_push("inv_matched2_busy", 0);
        do_flip(4'd1);
        sb_check(face_up);
        sb_check(busy);
        sb_push("m23_face_up_cmp", 16'h000C);
        sb_push("m23_moves", 3);
        do_flip(4'd3);
        sb_check(face_up);
        sb_check(moves);
        sb_push("m23_matched", 16'h000F);
        tick();
        sb_check(matched);

        for (int p = 2; p < 8; p++) begin
            do_flip(4'(2 * p));
            do_flip(4'(2 * p + 1));
            sb_push("pair_matched", 64'((32'h1 << (2 * p + 2)) - 1));
            sb_push("pair_moves", 64'(p + 2));
            tick();
            sb_check(matched);
            sb_check(moves);
        end
        sb_push("win_game_over", 1);
        sb_push("win_face_up", 0);
        sb_push("win_busy", 0);
        sb_push("win_game_lost", 0);
        sb_check(game_over);
        sb_check(face_up);
        sb_check(busy);
        sb_check(game_lost);

        sb_push("done_flip_matched", 16'hFFFF);
        sb_push("done_flip_moves", 9);
        sb_push("done_flip_game_over", 1);
        do_flip(4'd0);
        sb_check(matched);
        sb_check(moves);
        sb_check(game_over);

        // start_game beats a simultaneous flip; flips during the shuffle are dropped.
        run_shuffle(model_deck, 1'b1);

        do_flip(4'd0);
        do_flip(4'd2);
        tick(2);
        #2 reset = 1'b1;
        #1;
        check_reset_vals("async_reset");
        #1 reset = 1'b0;
        tick();
        run_shuffle(48'd0, 1'b0);

`ifdef CARD_FLIP_MOVE_LIMIT_EN
        mismatch_hold(4'd0, 4'd2, 8'd1);
        mismatch_hold(4'd0, 4'd2, 8'd2);
        do_flip(4'd0);
        sb_push("lose_moves", 3);
        do_flip(4'd2);
        sb_check(moves);
        sb_push("lose_game_over", 1);
        sb_push("lose_game_lost", 1);
        sb_push("lose_face_up", 0);
        sb_push("lose_busy", 0);
        tick();
        sb_check(game_over);
        sb_check(game_lost);
        sb_check(face_up);
        sb_check(busy);
`else
        mismatch_hold(4'd0, 4'd2, 8'd1);
        sb_push("nolimit_game_lost", 0);
        sb_push("nolimit_game_over", 0);
        sb_check(game_lost);
        sb_check(game_over);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
